pe_ofmap_drain: RTL

//  Receive-side drain for the 8-row PE array: captures one 8-lane opsum frame per

---
 rtl/pe_ofmap_drain.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pe_ofmap_drain.sv
// pe_ofmap_drain: buffers up to DEPTH opsum frames from the PE array and serializes
// them lane 0..LANES-1 onto a valid/ready stream. Optional build macro: RELU_QUANT_EN.
module pe_ofmap_drain #(
    parameter int LANES  = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [LANES*DATA_W-1:0]  in_ofmap,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(LANES)-1:0] out_lane,
    output logic                     out_last,
    input  logic [4:0]               shift_cfg,
    input  logic                     clr_ovf,
    output logic                     overflow,
    output logic [15:0]              frame_cnt
);
    localparam int LANE_W  = $clog2(LANES);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int FRAME_W = LANES * DATA_W;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t              state;
    logic [FRAME_W-1:0]  frame_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
    logic [CNT_W-1:0]    count, count_next;
    logic [LANE_W-1:0]   lane_inc;
    logic [DATA_W-1:0]   out_word;
    logic [FRAME_W-1:0]  cur_frame, next_frame;
    logic                full, beat, pop, push, drop;

    // NOTE: every signal gets a default at the top of the block so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        full       = (count == FULL_CNT);
        beat       = out_valid && out_ready;
        pop        = beat && (out_lane == LAST_LANE);
        push       = in_valid && (!full || pop);
        drop       = in_valid && full && !pop;
        wr_ptr_inc = wr_ptr + PTR_W'(1);
        rd_ptr_inc = rd_ptr + PTR_W'(1);
        lane_inc   = out_lane + LANE_W'(1);
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
        cur_frame  = frame_mem[rd_ptr];
        // A frame arriving on the pop edge may be the very next one to send.
        next_frame = (push && (wr_ptr == rd_ptr_inc)) ? in_ofmap : frame_mem[rd_ptr_inc];
    end

    // NOTE: the frame store has no reset; count and the pointers decide which slots
    // hold live data, so clearing the array would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            frame_mem[wr_ptr] <= in_ofmap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values
            // regardless of statement order.
            if (push) wr_ptr <= wr_ptr_inc;
            if (pop)  rd_ptr <= rd_ptr_inc;
            count    <= count_next;
            in_ready <= (count_next < FULL_CNT);
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_lane  <= '0;
            out_last  <= 1'b0;
            out_word  <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        out_lane  <= '0;
                        out_last  <= 1'b0;
                        out_word  <= cur_frame[0 +: DATA_W];
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (out_lane != LAST_LANE) begin
                            out_lane <= lane_inc;
                            out_last <= (lane_inc == LAST_LANE);
                            out_word <= cur_frame[int'(lane_inc) * DATA_W +: DATA_W];
                        end else begin
                            frame_cnt <= frame_cnt + 16'd1;
                            out_lane  <= '0;
                            out_last  <= 1'b0;
                            if (count_next != '0) begin
                                out_word <= next_frame[0 +: DATA_W];
                            end else begin
                                state     <= IDLE;
                                out_valid <= 1'b0;
                                out_word  <= '0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RELU_QUANT_EN
    logic [DATA_W-1:0] relu_word, shifted_word;

    always_comb begin
        relu_word    = out_word[DATA_W-1] ? '0 : out_word;
        shifted_word = relu_word >> shift_cfg;
        out_data     = '0;
        out_data[7:0] = (shifted_word > DATA_W'(255)) ? 8'hFF : shifted_word[7:0];
    end
`else
    logic unused_shift;

    assign unused_shift = ^shift_cfg;
    assign out_data     = out_word;
`endif

endmodule
